// File: rtl/axis_frame_arb.sv
// axis_frame_arb: round-robin, frame-granular AXI-Stream arbiter.
// One requesting input stream is granted from the first beat to its tlast beat,
// and its beats pass through a single registered output stage.
// The grant FSM state is visible on grant_valid (1 = ACTIVE).
// Optional feature: define AXIS_FRAME_ARB_TID_EN to carry the granted stream index
// on m_axis_tid. Without it, m_axis_tid is tied to 0 and no tid register is built.
//
// Handshake: a transfer happens on any edge where tvalid && tready on that side.
// A source holds tdata/tlast/tuser stable while tvalid is high and tready is low.
module axis_frame_arb #(
    parameter int S_COUNT    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    output logic [ID_WIDTH-1:0]           m_axis_tid,
    output logic                          grant_valid,
    output logic [ID_WIDTH-1:0]           grant_index,
    output logic [15:0]                   frame_count
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   grant_index_q, grant_index_d;
    logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_last_q, m_last_d;
    logic [USER_WIDTH-1:0] m_user_q, m_user_d;
    logic [15:0]           frame_count_q, frame_count_d;

    logic                  rr_found_hi, rr_found_lo;
    logic [ID_WIDTH-1:0]   rr_pick_hi, rr_pick_lo, rr_pick;
    logic                  rr_found;

    logic                  sel_valid, sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [USER_WIDTH-1:0] sel_user;
    logic                  s_ready_g;
    logic                  s_xfer, m_xfer;

    // Round-robin search: first requester above last_grant, else first at or below it.
    always_comb begin
        rr_found_hi = 1'b0;
        rr_found_lo = 1'b0;
        rr_pick_hi  = '0;
        rr_pick_lo  = '0;
        for (int j = 0; j < S_COUNT; j++) begin
            if (s_axis_tvalid[j] && !rr_found_hi && (ID_WIDTH'(j) > last_grant_q)) begin
                rr_found_hi = 1'b1;
                rr_pick_hi  = ID_WIDTH'(j);
            end
            if (s_axis_tvalid[j] && !rr_found_lo && (ID_WIDTH'(j) <= last_grant_q)) begin
                rr_found_lo = 1'b1;
                rr_pick_lo  = ID_WIDTH'(j);
            end
        end
        rr_found = rr_found_hi || rr_found_lo;
        rr_pick  = rr_found_hi ? rr_pick_hi : rr_pick_lo;
    end

    // Select the granted stream and steer tready back to it only.
    always_comb begin
        sel_valid     = 1'b0;
        sel_last      = 1'b0;
        sel_data      = '0;
        sel_user      = '0;
        s_axis_tready = '0;
        s_ready_g     = (state_q == ST_ACTIVE) && (m_axis_tready || !m_valid_q);
        for (int j = 0; j < S_COUNT; j++) begin
            if (grant_index_q == ID_WIDTH'(j)) begin
                sel_valid        = s_axis_tvalid[j];
                sel_last         = s_axis_tlast[j];
                sel_data         = s_axis_tdata[j*DATA_WIDTH +: DATA_WIDTH];
                sel_user         = s_axis_tuser[j*USER_WIDTH +: USER_WIDTH];
                s_axis_tready[j] = s_ready_g;
            end
        end
        s_xfer = s_ready_g && sel_valid;
        m_xfer = m_valid_q && m_axis_tready;
    end

    // Grant FSM: pick in IDLE, hold the grant until the tlast beat is accepted.
    always_comb begin
        state_d       = state_q;
        grant_index_d = grant_index_q;
        last_grant_d  = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (rr_found) begin
                    grant_index_d = rr_pick;
                    state_d       = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (s_xfer && sel_last) begin
                    last_grant_d = grant_index_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output register: load on an accepted beat, empty when drained without refill.
    always_comb begin
        m_valid_d     = m_valid_q;
        m_data_d      = m_data_q;
        m_last_d      = m_last_q;
        m_user_d      = m_user_q;
        frame_count_d = frame_count_q;
        if (m_xfer) begin
            m_valid_d = 1'b0;
        end
        if (s_xfer) begin
            m_valid_d = 1'b1;
            m_data_d  = sel_data;
            m_last_d  = sel_last;
            m_user_d  = sel_user;
        end
        if (m_xfer && m_last_q) begin
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            grant_index_q <= '0;
            last_grant_q  <= ID_WIDTH'(S_COUNT - 1);
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
            m_last_q      <= 1'b0;
            m_user_q      <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_index_q <= grant_index_d;
            last_grant_q  <= last_grant_d;
            m_valid_q     <= m_valid_d;
            m_data_q      <= m_data_d;
            m_last_q      <= m_last_d;
            m_user_q      <= m_user_d;
            frame_count_q <= frame_count_d;
        end
    end

`ifdef AXIS_FRAME_ARB_TID_EN
    logic [ID_WIDTH-1:0] m_tid_q, m_tid_d;

    // Capture the granted index alongside each accepted beat.
    always_comb begin
        m_tid_d = m_tid_q;
        if (s_xfer) begin
            m_tid_d = grant_index_q;
        end
    end

    // tid register.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_tid_q <= '0;
        end else begin
            m_tid_q <= m_tid_d;
        end
    end

    assign m_axis_tid = m_tid_q;
`else
    assign m_axis_tid = '0;
`endif

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tuser  = m_user_q;
    assign grant_valid   = (state_q == ST_ACTIVE);
    assign grant_index   = grant_index_q;
    assign frame_count   = frame_count_q;

endmodule
